// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the three channels that surround the fetch queue:
//     - instruction-memory issue/response channel (mem_*)
//     - IF/ID presentation channel (if_*)
//     - branch redirect (redirect, redirect_pc)
//   master : the fetch queue itself (drives mem_req/mem_addr and if_*)
//   slave  : the surrounding pipeline / memory (drives everything else)
// Parameters:
//   PC_W    fetch PC width (word address)
//   INSTR_W instruction width
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;

    logic               if_valid;
    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               if_ready;

    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output mem_req, mem_addr, if_valid, if_pc, if_instr,
        input  mem_ready, mem_rvalid, mem_rdata, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, if_valid, if_pc, if_instr,
        output mem_ready, mem_rvalid, mem_rdata, if_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage in front of the IF/ID register. Owns the fetch PC,
//   issues word-addressed requests to instruction memory, buffers in-order
//   responses with their PC in a DEPTH-entry ring, and presents one
//   instruction per cycle to IF/ID. A redirect flushes the ring and discards
//   responses still in flight before fetching from the new target.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      fetch_queue_if.master: mem_req/mem_addr/mem_ready issue channel,
//            mem_rvalid/mem_rdata in-order responses, if_valid/if_pc/if_instr/
//            if_ready towards IF/ID, redirect/redirect_pc branch redirect
// Configuration:
//   FETCH_QUEUE_BYPASS_EN  when defined, a response arriving for an empty
//                          queue is presented to IF/ID in the same cycle.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset_n,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [PC_W-1:0]    fpc;
    logic [PC_W-1:0]    ent_pc    [DEPTH];
    logic [INSTR_W-1:0] ent_instr [DEPTH];
    logic [DEPTH-1:0]   ent_filled;
    cnt_t               alloc_ptr, fill_ptr, rd_ptr, count, drop_cnt;
    logic [PC_W-1:0]    hold_pc;
    logic [INSTR_W-1:0] hold_instr;

    logic [AW-1:0] alloc_idx, fill_idx, rd_idx;
    cnt_t          unfilled, count_next, drop_next;
    logic          head_filled, head_show, fill_hit, fill_store, issue, pop;

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];

    // Pointers run over 2*DEPTH, so the difference is the exact number of
    // allocated entries still waiting for their response.
    assign unfilled    = alloc_ptr - fill_ptr;
    assign head_filled = ent_filled[rd_idx] && (count != '0);
    assign fill_hit    = bus.mem_rvalid && (drop_cnt == '0) && (unfilled != '0);

    // Requests stop while reset is held, during a redirect, while stale
    // responses are being drained, and when queued + in-flight reaches DEPTH.
    assign bus.mem_req  = reset_n && !bus.redirect && (drop_cnt == '0) && (count < DEPTH_C);
    assign bus.mem_addr = fpc;
    assign issue        = bus.mem_req && bus.mem_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;
    // fill_ptr == rd_ptr means nothing is filled yet, so this response
    // belongs to the head entry and can be shown straight away.
    assign bypass_hit   = fill_hit && (fill_ptr == rd_ptr);
    assign head_show    = head_filled || bypass_hit;
    assign bus.if_instr = head_filled ? ent_instr[rd_idx]
                        : (bypass_hit ? bus.mem_rdata : hold_instr);
    // A bypassed response taken by IF/ID frees its entry without storing it.
    assign fill_store   = fill_hit && !(bypass_hit && bus.if_ready);
`else
    assign head_show    = head_filled;
    assign bus.if_instr = head_filled ? ent_instr[rd_idx] : hold_instr;
    assign fill_store   = fill_hit;
`endif

    // When nothing is presented, the outputs keep the last presented values.
    assign bus.if_pc    = head_show ? ent_pc[rd_idx] : hold_pc;
    assign bus.if_valid = head_show && !bus.redirect;
    assign pop          = bus.if_valid && bus.if_ready;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        count_next = count;
        if (issue && !pop)
            count_next = count + cnt_t'(1);
        else if (pop && !issue)
            count_next = count - cnt_t'(1);

        // Responses still owed after a redirect: carried-over drops plus
        // unfilled entries, less the one arriving in this very cycle.
        drop_next = drop_cnt + unfilled;
        if (bus.mem_rvalid && (drop_next != '0))
            drop_next = drop_next - cnt_t'(1);
    end

    // NOTE: state registers use non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fpc        <= RESET_PC;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_cnt   <= '0;
            ent_filled <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (bus.redirect) begin
            fpc        <= bus.redirect_pc;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_cnt   <= drop_next;
            ent_filled <= '0;
        end else begin
            if ((drop_cnt != '0) && bus.mem_rvalid)
                drop_cnt <= drop_cnt - cnt_t'(1);
            if (fill_hit)
                fill_ptr <= fill_ptr + cnt_t'(1);
            if (fill_store)
                ent_filled[fill_idx] <= 1'b1;
            if (pop) begin
                ent_filled[rd_idx] <= 1'b0;
                rd_ptr             <= rd_ptr + cnt_t'(1);
            end
            if (issue) begin
                alloc_ptr <= alloc_ptr + cnt_t'(1);
                fpc       <= fpc + 1'b1;
            end
            if (bus.if_valid) begin
                hold_pc    <= bus.if_pc;
                hold_instr <= bus.if_instr;
            end
            count <= count_next;
        end
    end

    // NOTE: the payload arrays have no reset; ent_filled alone marks which slots hold data.
    always_ff @(posedge clk) begin
        if (issue)
            ent_pc[alloc_idx] <= fpc;
        if (fill_store && !bus.redirect)
            ent_instr[fill_idx] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int              DEPTH    = 4;
    localparam int              PC_W     = 64;
    localparam int              INSTR_W  = 32;
    localparam logic [PC_W-1:0] RESET_PC = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT0 = BYP ? 0 : 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_0000;
    endfunction

    // ---------------- reference model: queue of {pc, instr, filled} ----------
    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        bit                 filled;
    } ent_t;
    ent_t            mq[$];
    logic [PC_W-1:0] m_fpc;
    int              m_drop;

    // ---------------- memory model: in-order responses with latency ----------
    typedef struct {
        logic [PC_W-1:0] addr;
        int              due;
    } rsp_t;
    rsp_t pend[$];
    int   cyc;

    // stimulus knobs
    bit              k_ready, k_if_ready, k_redirect, k_hold;
    logic [PC_W-1:0] k_rpc;
    int              k_lat_min, k_lat_max;

    // what the DUT did in the most recent cycle
    bit                 ev_acc, ev_pop, ev_req, ev_rvalid, ev_valid;
    logic [PC_W-1:0]    ev_addr, ev_pc;
    logic [INSTR_W-1:0] ev_instr;

    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_fpc  = RESET_PC;
        m_drop = 0;
        cyc    = 0;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        k_ready = 1'b0; k_if_ready = 1'b0; k_redirect = 1'b0; k_hold = 1'b0;
        k_rpc = '0; k_lat_min = 1; k_lat_max = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, RESET_PC);
        check("rst_if_valid", bus.if_valid, 1'b0);
        check("rst_if_pc", bus.if_pc, '0);
        check("rst_if_instr", bus.if_instr, '0);
        model_reset();
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare against the model at the falling
    // edge, then advance model and memory at the rising edge.
    task automatic cycle();
        bit                 e_req, e_valid, head_f, byp, done;
        int                 u, p, lat;
        bus.mem_ready   = k_ready;
        bus.if_ready    = k_if_ready;
        bus.redirect    = k_redirect;
        bus.redirect_pc = k_rpc;
        if (!k_hold && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = instr_of(pend[0].addr);
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        @(negedge clk);
        u = 0;
        foreach (mq[i]) if (!mq[i].filled) u++;
        assert (!(bus.mem_rvalid && m_drop == 0 && u == 0)) else begin
            n_chk++;
            n_err++;
            $display("FAIL rvalid_without_request: response with no outstanding entry (t=%0t)", $time);
        end
        head_f  = (mq.size() > 0) && mq[0].filled;
        byp     = BYP && (mq.size() > 0) && !mq[0].filled && bus.mem_rvalid && (m_drop == 0);
        e_req   = !k_redirect && (m_drop == 0) && (mq.size() < DEPTH);
        e_valid = !k_redirect && (head_f || byp);
        check("mem_req", bus.mem_req, e_req);
        if (e_req) check("mem_addr", bus.mem_addr, m_fpc);
        check("if_valid", bus.if_valid, e_valid);
        if (e_valid) begin
            check("if_pc", bus.if_pc, mq[0].pc);
            check("if_instr", bus.if_instr, head_f ? mq[0].instr : bus.mem_rdata);
        end
        check("count", 64'(dut.count), 64'(mq.size()));
        ev_req    = bus.mem_req;
        ev_acc    = bus.mem_req && k_ready;
        ev_addr   = bus.mem_addr;
        ev_rvalid = bus.mem_rvalid;
        ev_valid  = bus.if_valid;
        ev_pop    = bus.if_valid && k_if_ready;
        ev_pc     = bus.if_pc;
        ev_instr  = bus.if_instr;
        @(posedge clk);
        if (k_redirect) begin
            p = m_drop + u;
            if (bus.mem_rvalid && p > 0) p--;
            m_drop = p;
            mq.delete();
            m_fpc = k_rpc;
        end else begin
            if (bus.mem_rvalid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    done = 1'b0;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!done && !mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].instr  = bus.mem_rdata;
                            done = 1'b1;
                        end
                    end
                end
            end
            if (e_valid && k_if_ready) void'(mq.pop_front());
            if (e_req && k_ready) begin
                mq.push_back('{pc: m_fpc, instr: '0, filled: 1'b0});
                m_fpc = m_fpc + 1'b1;
            end
        end
        if (bus.mem_rvalid) void'(pend.pop_front());
        if (ev_acc) begin
            lat = $urandom_range(k_lat_max, k_lat_min);
            pend.push_back('{addr: ev_addr, due: cyc + lat});
        end
        cyc++;
        #1;
    endtask

    // ---------------- directed vector table ----------------------------------
    typedef struct {
        bit                 ready, rvalid, if_ready, redirect;
        logic [PC_W-1:0]    rpc;
        logic [INSTR_W-1:0] rdata;
        bit                 e_req;
        logic [PC_W-1:0]    e_addr;
        bit                 e_valid;
        logic [PC_W-1:0]    e_pc;
        logic [INSTR_W-1:0] e_instr;
    } vec_t;
    vec_t vec[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_cnt, n_pop, n_drop;
        bit  seen;
        logic [PC_W-1:0] exp_pc;

        // Back-to-back stream with one-cycle memory, then redirect with a
        // same-cycle response (dropped) and refetch from the target.
        for (int i = 0; i < 8; i++)
            vec[i] = '{ready: 1'b1, rvalid: (i >= 1), if_ready: 1'b1, redirect: 1'b0, rpc: '0,
                       rdata: instr_of(PC_W'(i - 1)), e_req: 1'b1, e_addr: PC_W'(i),
                       e_valid: (i >= 1 + LAT0), e_pc: PC_W'(i - 1 - LAT0),
                       e_instr: instr_of(PC_W'(i - 1 - LAT0))};
        vec[8]  = '{ready: 1'b1, rvalid: 1'b1, if_ready: 1'b1, redirect: 1'b1, rpc: 64'h40,
                    rdata: instr_of(64'd7), e_req: 1'b0, e_addr: '0, e_valid: 1'b0, e_pc: '0, e_instr: '0};
        vec[9]  = '{ready: 1'b1, rvalid: 1'b0, if_ready: 1'b1, redirect: 1'b0, rpc: '0,
                    rdata: '0, e_req: 1'b1, e_addr: 64'h40, e_valid: 1'b0, e_pc: '0, e_instr: '0};
        vec[10] = '{ready: 1'b1, rvalid: 1'b1, if_ready: 1'b1, redirect: 1'b0, rpc: '0,
                    rdata: instr_of(64'h40), e_req: 1'b1, e_addr: 64'h41, e_valid: (LAT0 == 0),
                    e_pc: 64'h40, e_instr: instr_of(64'h40)};
        vec[11] = '{ready: 1'b1, rvalid: 1'b1, if_ready: 1'b1, redirect: 1'b0, rpc: '0,
                    rdata: instr_of(64'h41), e_req: 1'b1, e_addr: 64'h42, e_valid: 1'b1,
                    e_pc: PC_W'(64'h41 - LAT0), e_instr: instr_of(PC_W'(64'h41 - LAT0))};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.mem_ready   = vec[i].ready;
            bus.mem_rvalid  = vec[i].rvalid;
            bus.mem_rdata   = vec[i].rdata;
            bus.if_ready    = vec[i].if_ready;
            bus.redirect    = vec[i].redirect;
            bus.redirect_pc = vec[i].rpc;
            @(negedge clk);
            check($sformatf("vec%0d_mem_req", i), bus.mem_req, vec[i].e_req);
            if (vec[i].e_req) check($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vec[i].e_addr);
            check($sformatf("vec%0d_if_valid", i), bus.if_valid, vec[i].e_valid);
            if (vec[i].e_valid) begin
                check($sformatf("vec%0d_if_pc", i), bus.if_pc, vec[i].e_pc);
                check($sformatf("vec%0d_if_instr", i), bus.if_instr, vec[i].e_instr);
            end
            @(posedge clk);
            #1;
        end

        // Stall: if_ready low for 10 cycles fills the queue, then drains in order.
        do_reset();
        k_ready = 1'b1; k_if_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (ev_acc) acc_cnt++;
            if (ev_valid) check("stall_hold_pc", ev_pc, '0);
        end
        check("stall_issued", acc_cnt, 4);
        check("stall_req_low", ev_req, 1'b0);
        k_if_ready = 1'b1;
        n_pop = 0; seen = 1'b0;
        for (int i = 0; i < 20 && n_pop < 4; i++) begin
            cycle();
            if (ev_pop) begin
                check("drain_pc", ev_pc, PC_W'(n_pop));
                check("drain_instr", ev_instr, instr_of(PC_W'(n_pop)));
                n_pop++;
            end
            if (ev_acc && !seen) begin
                seen = 1'b1;
                check("resume_addr", ev_addr, 64'd4);
            end
        end
        check("drain_count", n_pop, 4);
        check("resume_seen", seen, 1'b1);

        // Redirect with two requests in flight: both responses dropped.
        do_reset();
        k_ready = 1'b1; k_if_ready = 1'b1; k_hold = 1'b1;
        cycle();
        cycle();
        k_redirect = 1'b1; k_rpc = 64'h40;
        cycle();
        k_redirect = 1'b0; k_hold = 1'b0;
        n_drop = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (ev_acc) begin
                seen = 1'b1;
                check("redir_first_addr", ev_addr, 64'h40);
            end else if (ev_rvalid) n_drop++;
        end
        check("redir_dropped", n_drop, 2);
        check("redir_req_seen", seen, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (ev_pop) begin
                seen = 1'b1;
                check("redir_first_pc", ev_pc, 64'h40);
                check("redir_first_instr", ev_instr, instr_of(64'h40));
            end
        end
        check("redir_pop_seen", seen, 1'b1);

        // Redirect in the same cycle as the only outstanding response.
        do_reset();
        k_ready = 1'b1; k_if_ready = 1'b1;
        cycle();
        k_redirect = 1'b1; k_rpc = 64'h80;
        cycle();
        check("same_cycle_rvalid", ev_rvalid, 1'b1);
        k_redirect = 1'b0;
        cycle();
        check("same_cycle_req", ev_req, 1'b1);
        check("same_cycle_addr", ev_addr, 64'h80);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (ev_pop) begin
                seen = 1'b1;
                check("same_cycle_first_pc", ev_pc, 64'h80);
            end
        end
        check("same_cycle_pop_seen", seen, 1'b1);

        // Random ready / latency / back-pressure, 200 instructions in sequence.
        do_reset();
        k_lat_min = 1; k_lat_max = 5;
        exp_pc = RESET_PC; n_pop = 0;
        for (int i = 0; i < 4000 && n_pop < 200; i++) begin
            k_ready    = ($urandom_range(9, 0) < 7);
            k_if_ready = ($urandom_range(3, 0) != 0);
            cycle();
            if (ev_pop) begin
                check("seq_pc", ev_pc, exp_pc);
                check("seq_instr", ev_instr, instr_of(exp_pc));
                exp_pc = exp_pc + 1'b1;
                n_pop++;
            end
        end
        check("seq_total", n_pop, 200);

        // Random traffic with occasional redirects, including a PC near wrap.
        for (int i = 0; i < 600; i++) begin
            k_ready    = ($urandom_range(9, 0) < 7);
            k_if_ready = ($urandom_range(3, 0) != 0);
            k_redirect = ($urandom_range(24, 0) == 0);
            case ($urandom_range(2, 0))
                0:       k_rpc = {$urandom, $urandom};
                1:       k_rpc = 64'hFFFF_FFFF_FFFF_FFFE;
                default: k_rpc = 64'h40;
            endcase
            cycle();
        end
        k_redirect = 1'b0;

        // Reset asserted with a full queue, then restart from RESET_PC.
        do_reset();
        k_ready = 1'b1; k_if_ready = 1'b0;
        repeat (8) cycle();
        check("full_req_low", ev_req, 1'b0);
        check("full_valid", ev_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_if_valid", bus.if_valid, 1'b0);
        check("midrst_mem_req", bus.mem_req, 1'b0);
        do_reset();
        #1;
        check("post_rst_req", bus.mem_req, 1'b1);
        check("post_rst_addr", bus.mem_addr, RESET_PC);
        k_ready = 1'b1; k_if_ready = 1'b1;
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
